// File: rtl/otter_lsu_pkg.sv
// rtl/otter_lsu_pkg.sv - shared state, size codes and crossing test for otter_lsu (RD1/STB exist only with LSU_MISALIGN_SPLIT_EN)
package otter_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
`ifdef LSU_MISALIGN_SPLIT_EN
    RD1,
    STB,
`endif
    RDW,
    ST,
    RSP
  } lsu_state_t;

  // An access crosses a word boundary when its bytes do not all fit in one aligned word
  function automatic logic is_crossing(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_WORD) && (off != 2'd0)) || ((size == SZ_HALF) && (off == 2'd3));
  endfunction

endpackage

// File: rtl/otter_lsu_if.sv
// rtl/otter_lsu_if.sv - request/response handshake and memory port 2 bundle for otter_lsu
interface otter_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_sign;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] mem_addr2;
  logic [31:0] mem_din2;
  logic        mem_write2;
  logic        mem_read2;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_dout2;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_sign, mem_dout2,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr2, mem_din2, mem_write2, mem_read2, mem_size, mem_sign
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_sign, mem_dout2,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr2, mem_din2, mem_write2, mem_read2, mem_size, mem_sign
  );

endinterface

// File: rtl/otter_lsu_load_align.sv
// rtl/otter_lsu_load_align.sv - shifts a two-word window by the byte offset and extends to 32 bits
module otter_lsu_load_align
  import otter_lsu_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  assign sh = 32'(data_i >> {off_i, 3'b000});

  // Truncate to the access size and extend; sign_i=1 means zero-extend
  always_comb begin
    data_o = sh;
    case (size_i)
      SZ_BYTE: data_o = sign_i ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: data_o = sign_i ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/otter_lsu.sv
// rtl/otter_lsu.sv - OTTER port-2 load/store unit; define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
  parameter int          ACTUAL_WIDTH = 14
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  otter_lsu_if.slave lsu
);

  localparam logic [32:0] RAM_END = 33'd4 << ACTUAL_WIDTH;

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        sign_q, err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic        cross_q;
  logic [31:0] lo_q;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_last;
`endif

  logic        accept;
  logic        req_cross, req_hole, req_err;
  logic [1:0]  req_span;
  logic [32:0] req_last;

  logic [63:0] al_data;
  logic [1:0]  al_off, al_size;
  logic        al_sign;
  logic [31:0] al_out;

  assign lsu.req_ready = (state_q == IDLE) || (state_q == RSP);
  assign accept        = lsu.req_valid && lsu.req_ready;
  assign lsu.rsp_err   = (state_q == RSP) && err_q;
  assign lsu.rsp_rdata = (state_q == RSP) ? rdata_q : 32'h0;

  // Classify the incoming request: illegal size, crossing, or touching the unmapped hole
  always_comb begin
    req_cross = is_crossing(lsu.req_size, lsu.req_addr[1:0]);
    case (lsu.req_size)
      SZ_BYTE: req_span = 2'd0;
      SZ_HALF: req_span = 2'd1;
      default: req_span = 2'd3;
    endcase
    req_last = {1'b0, lsu.req_addr} + {31'd0, req_span};
    req_hole = ({1'b0, lsu.req_addr} < {1'b0, IO_BASE}) && (req_last >= RAM_END);
    req_err  = (lsu.req_size == 2'd3) || (req_cross && (lsu.req_addr >= IO_BASE)) || req_hole;
`ifndef LSU_MISALIGN_SPLIT_EN
    req_err  = req_err || req_cross;
`endif
  end

  // Aligned and MMIO loads pass memory data through; crossing loads merge lo/hi words
  always_comb begin
    al_data = {32'h0, lsu.mem_dout2};
    al_off  = 2'd0;
    al_size = SZ_WORD;
    al_sign = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
    if (cross_q) begin
      al_data = {lsu.mem_dout2, lo_q};
      al_off  = addr_q[1:0];
      al_size = size_q;
      al_sign = sign_q;
    end
`endif
  end

  otter_lsu_load_align u_align (
    .data_i (al_data),
    .off_i  (al_off),
    .size_i (al_size),
    .sign_i (al_sign),
    .data_o (al_out)
  );

`ifdef LSU_MISALIGN_SPLIT_EN
  assign cnt_last = (size_q == SZ_HALF) ? 2'd1 : 2'd3;
`endif

  // Next state and memory strobes, decoded from the current state and latched request
  always_comb begin
    state_d        = state_q;
    lsu.rsp_valid  = 1'b0;
    lsu.mem_read2  = 1'b0;
    lsu.mem_write2 = 1'b0;
    lsu.mem_addr2  = 32'h0;
    lsu.mem_din2   = 32'h0;
    lsu.mem_size   = SZ_BYTE;
    lsu.mem_sign   = 1'b0;
    case (state_q)
      IDLE, RSP: begin
        lsu.rsp_valid = (state_q == RSP);
        if (!accept)            state_d = IDLE;
        else if (req_err)       state_d = RSP;
        else if (!lsu.req_we)   state_d = RD0;
`ifdef LSU_MISALIGN_SPLIT_EN
        else if (req_cross)     state_d = STB;
`endif
        else                    state_d = ST;
      end
      RD0: begin
        lsu.mem_read2 = 1'b1;
        lsu.mem_addr2 = addr_q;
        lsu.mem_size  = size_q;
        lsu.mem_sign  = sign_q;
        state_d       = RDW;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (cross_q) begin
          lsu.mem_addr2 = {addr_q[31:2], 2'b00};
          lsu.mem_size  = SZ_WORD;
          lsu.mem_sign  = 1'b0;
          state_d       = RD1;
        end
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      RD1: begin
        lsu.mem_read2 = 1'b1;
        lsu.mem_addr2 = {addr_q[31:2], 2'b00} + 32'd4;
        lsu.mem_size  = SZ_WORD;
        state_d       = RDW;
      end
      STB: begin
        lsu.mem_write2 = 1'b1;
        lsu.mem_addr2  = addr_q + {30'd0, cnt_q};
        lsu.mem_din2   = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
        lsu.mem_size   = SZ_BYTE;
        if (cnt_q == cnt_last) state_d = RSP;
      end
`endif
      RDW: state_d = RSP;
      ST: begin
        lsu.mem_write2 = 1'b1;
        lsu.mem_addr2  = addr_q;
        lsu.mem_din2   = wdata_q;
        lsu.mem_size   = size_q;
        lsu.mem_sign   = sign_q;
        state_d        = RSP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any request in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Latch the request on accept, then collect load data and step the byte counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q <= 1'b0;
      lo_q    <= 32'h0;
      cnt_q   <= 2'd0;
`endif
    end else if (accept) begin
      addr_q  <= lsu.req_addr;
      wdata_q <= lsu.req_wdata;
      size_q  <= lsu.req_size;
      sign_q  <= lsu.req_sign;
      err_q   <= req_err;
      rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q <= req_cross;
      cnt_q   <= 2'd0;
`endif
    end else begin
      if (state_q == RDW) rdata_q <= al_out;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state_q == RD1) lo_q  <= lsu.mem_dout2;
      if (state_q == STB) cnt_q <= cnt_q + 2'd1;
`endif
    end
  end

endmodule

// File: tb/tb_otter_lsu.sv
// tb/tb_otter_lsu.sv - directed self-checking bench for otter_lsu with a byte-addressed memory model
module tb_otter_lsu;
  import otter_lsu_pkg::*;

  localparam logic [31:0] IO_BASE = 32'h1100_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otter_lsu_if bus();

  otter_lsu #(.IO_BASE(IO_BASE), .ACTUAL_WIDTH(14)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .lsu     (bus)
  );

  logic [7:0]  ram [0:65535];
  logic [31:0] io_in;
  logic [31:0] rd_addr_log [$];
  logic [31:0] wr_addr_log [$];
  logic [1:0]  wr_size_log [$];
  logic [31:0] wr_din_log  [$];
  int          both_strobes = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] s, input logic g);
    logic [7:0] b0, b1, b2, b3;
    if (a >= IO_BASE) return io_in;
    b0 = ram[a[15:0]];
    b1 = ram[a[15:0] + 16'd1];
    b2 = ram[a[15:0] + 16'd2];
    b3 = ram[a[15:0] + 16'd3];
    case (s)
      2'd0:    return g ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'd1:    return g ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mem_read2 && bus.mem_write2) both_strobes <= both_strobes + 1;
    if (bus.mem_read2) begin
      rd_addr_log.push_back(bus.mem_addr2);
      bus.mem_dout2 <= mem_read(bus.mem_addr2, bus.mem_size, bus.mem_sign);
    end
    if (bus.mem_write2) begin
      wr_addr_log.push_back(bus.mem_addr2);
      wr_size_log.push_back(bus.mem_size);
      wr_din_log.push_back(bus.mem_din2);
      if (bus.mem_addr2 < 32'h0001_0000) begin
        ram[bus.mem_addr2[15:0]] <= bus.mem_din2[7:0];
        if (bus.mem_size != 2'd0) ram[bus.mem_addr2[15:0] + 16'd1] <= bus.mem_din2[15:8];
        if (bus.mem_size == 2'd2) begin
          ram[bus.mem_addr2[15:0] + 16'd2] <= bus.mem_din2[23:16];
          ram[bus.mem_addr2[15:0] + 16'd3] <= bus.mem_din2[31:24];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr_log.delete();
    wr_addr_log.delete();
    wr_size_log.delete();
    wr_din_log.delete();
  endtask

  // Issue one request; lat counts posedges from the accepting edge to the response cycle
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] s, input logic g,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    clear_logs();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_size  = s;
    bus.req_sign  = g;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  task automatic chk_load(input string tag, input logic [31:0] a, input logic [1:0] s,
                          input logic g, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b0, a, 32'h0, s, g, rd, er, lat);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, {31'd0, er}, 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_nrd"}, 32'(rd_addr_log.size()), 32'd1);
    check({tag, "_rdaddr"}, (rd_addr_log.size() > 0) ? rd_addr_log[0] : 32'hFFFF_FFFF, a);
  endtask

  task automatic chk_err(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] s, input logic g);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(we, a, wd, s, g, rd, er, lat);
    check({tag, "_err"}, {31'd0, er}, 32'd1);
    check({tag, "_data"}, rd, 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_strobes"}, 32'(rd_addr_log.size() + wr_addr_log.size()), 32'd0);
  endtask

  task automatic chk_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] s);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, a, wd, s, 1'b0, rd, er, lat);
    check({tag, "_err"}, {31'd0, er}, 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_nwr"}, 32'(wr_addr_log.size()), 32'd1);
    check({tag, "_wraddr"}, (wr_addr_log.size() > 0) ? wr_addr_log[0] : 32'hFFFF_FFFF, a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          seen;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_size  = 2'd0;
    bus.req_sign  = 1'b0;
    io_in         = 32'hDEAD_BEEF;
    for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
    for (int i = 0; i < 4; i++) begin
      ram[16'(256 + i)] <= 8'(32'h4433_2211 >> (8 * i));
      ram[16'(260 + i)] <= 8'(32'h8877_6655 >> (8 * i));
      ram[16'(512 + i)] <= 8'(80 + i);
      ram[16'(516 + i)] <= 8'(84 + i);
    end
    ram[16'hFFFF] <= 8'hC3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_flags", {28'd0, bus.rsp_valid, bus.rsp_err, bus.mem_write2, bus.mem_read2}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mem_addr", bus.mem_addr2, 32'd0);
    check("rst_mem_din", bus.mem_din2, 32'd0);
    check("rst_size_sign", {29'd0, bus.mem_size, bus.mem_sign}, 32'd0);
    rst_n = 1'b1;

    chk_load("lw_100", 32'h100, SZ_WORD, 1'b0, 32'h4433_2211);
    chk_load("lh_106", 32'h106, SZ_HALF, 1'b0, 32'hFFFF_8877);
    chk_load("lhu_106", 32'h106, SZ_HALF, 1'b1, 32'h0000_8877);
    chk_load("lh_101", 32'h101, SZ_HALF, 1'b0, 32'h0000_3322);
    chk_load("lb_107", 32'h107, SZ_BYTE, 1'b0, 32'hFFFF_FF88);
    chk_load("lbu_107", 32'h107, SZ_BYTE, 1'b1, 32'h0000_0088);
    chk_load("lw_ramtop", 32'hFFFC, SZ_WORD, 1'b0, 32'hC300_0000);
    chk_load("lw_io", IO_BASE, SZ_WORD, 1'b0, 32'hDEAD_BEEF);

    // Back-to-back: an illegal-size request, then a load held valid through its response cycle
    clear_logs();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h100;
    bus.req_size  = 2'd3;
    bus.req_sign  = 1'b0;
    @(posedge clk);
    #1 bus.req_size = SZ_WORD;
    @(negedge clk);
    check("b2b_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("b2b_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    check("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat", 32'(lat), 32'd3);
    check("b2b_data", bus.rsp_rdata, 32'h4433_2211);
    check("b2b_err", {31'd0, bus.rsp_err}, 32'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
    do_req(1'b0, 32'h101, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check("lw_101_data", rd, 32'h5544_3322);
    check("lw_101_err", {31'd0, er}, 32'd0);
    check("lw_101_lat", 32'(lat), 32'd4);
    check("lw_101_nrd", 32'(rd_addr_log.size()), 32'd2);
    check("lw_101_rd0", (rd_addr_log.size() > 1) ? rd_addr_log[0] : 32'hFFFF_FFFF, 32'h100);
    check("lw_101_rd1", (rd_addr_log.size() > 1) ? rd_addr_log[1] : 32'hFFFF_FFFF, 32'h104);
    do_req(1'b0, 32'h103, 32'h0, SZ_HALF, 1'b0, rd, er, lat);
    check("lh_103_data", rd, 32'h0000_5544);
    check("lh_103_lat", 32'(lat), 32'd4);
    do_req(1'b0, 32'h103, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check("lw_103_data", rd, 32'h7766_5544);
    do_req(1'b0, 32'h106, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check("lw_106_data", rd, 32'h0000_8877);
`else
    chk_err("lw_101", 1'b0, 32'h101, 32'h0, SZ_WORD, 1'b0);
    chk_err("lh_103", 1'b0, 32'h103, 32'h0, SZ_HALF, 1'b0);
`endif

    chk_store("sw_108", 32'h108, 32'h1234_5678, SZ_WORD);
    check("sw_108_din", (wr_din_log.size() > 0) ? wr_din_log[0] : 32'h0, 32'h1234_5678);
    chk_load("lw_108a", 32'h108, SZ_WORD, 1'b0, 32'h1234_5678);
    chk_store("sb_10b", 32'h10B, 32'h0000_009A, SZ_BYTE);
    chk_store("sh_109", 32'h109, 32'h0000_BEEF, SZ_HALF);
    chk_load("lw_108b", 32'h108, SZ_WORD, 1'b0, 32'h9ABE_EF78);

`ifdef LSU_MISALIGN_SPLIT_EN
    do_req(1'b1, 32'h102, 32'hAABB_CCDD, SZ_WORD, 1'b0, rd, er, lat);
    check("sw_102_err", {31'd0, er}, 32'd0);
    check("sw_102_lat", 32'(lat), 32'd5);
    check("sw_102_nwr", 32'(wr_addr_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wr_addr_log.size()) begin
        check("sw_102_addr", wr_addr_log[k], 32'(32'h102 + k));
        check("sw_102_size", {30'd0, wr_size_log[k]}, 32'd0);
        check("sw_102_byte", {24'd0, wr_din_log[k][7:0]}, 32'(8'(32'hAABB_CCDD >> (8 * k))));
      end
    end
    chk_load("lw_100_after", 32'h100, SZ_WORD, 1'b0, 32'hCCDD_2211);
    chk_load("lw_104_after", 32'h104, SZ_WORD, 1'b0, 32'h8877_AABB);
`else
    chk_err("sw_102", 1'b1, 32'h102, 32'hAABB_CCDD, SZ_WORD, 1'b0);
    chk_load("lw_100_after", 32'h100, SZ_WORD, 1'b0, 32'h4433_2211);
    chk_load("lw_104_after", 32'h104, SZ_WORD, 1'b0, 32'h8877_6655);
`endif

    chk_err("sw_io_cross", 1'b1, IO_BASE + 32'd2, 32'h1111_2222, SZ_WORD, 1'b0);
    chk_err("lw_hole", 1'b0, 32'h0001_0000, 32'h0, SZ_WORD, 1'b0);
    chk_err("lb_hole_top", 1'b0, IO_BASE - 32'd1, 32'h0, SZ_BYTE, 1'b0);
    chk_err("lh_ffff", 1'b0, 32'hFFFF, 32'h0, SZ_HALF, 1'b0);
    chk_err("lsz3", 1'b0, 32'h100, 32'h0, 2'd3, 1'b0);
    chk_err("ssz3", 1'b1, 32'h100, 32'h5555_5555, 2'd3, 1'b0);

    // Reset while a store is writing: strobe must drop at once and nothing more is written
    clear_logs();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'hAABB_CCDD;
    bus.req_size  = SZ_WORD;
    bus.req_sign  = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    bus.req_addr  = 32'h202;
`else
    bus.req_addr  = 32'h200;
`endif
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    @(posedge clk);
`endif
    @(negedge clk);
    check("rstmid_write_on", {31'd0, bus.mem_write2}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_write_drop", {31'd0, bus.mem_write2}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("rstmid_no_rsp", {31'd0, seen}, 32'd0);
    check("rstmid_ready", {31'd0, bus.req_ready}, 32'd1);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("rstmid_nwr", 32'(wr_addr_log.size()), 32'd1);
    check("rstmid_mem", {ram[16'h205], ram[16'h204], ram[16'h203], ram[16'h202]}, 32'h5554_53DD);
`else
    check("rstmid_nwr", 32'(wr_addr_log.size()), 32'd0);
    check("rstmid_mem", {ram[16'h203], ram[16'h202], ram[16'h201], ram[16'h200]}, 32'h5352_5150);
`endif

    check("no_dual_strobe", 32'(both_strobes), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
